move_entry: RTL and testbench

Player-input front end for the Corral game core. Synchronises and debounces the enter push-button and the 3-bit move switches, and rejects illegal move codes. Delivers each accepted move to the game core over the `enter`/`move` → `ready` handshake. Sits between the top-level pins and the game core, on the initiator side of the interface the core responds to.

---
 rtl/corral_pkg.sv | 19 +
 rtl/debounce.sv | 49 ++++
 rtl/move_entry.sv | 128 ++++++++++++
 tb/tb_move_entry.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/corral_pkg.sv
// Shared types and constants for the Corral player-input front end.
//   entry_state_t : move_entry FSM states
//   move_t        : signed 3-bit move step
//   MOVE_ILLEGAL  : the one code that has no legal meaning (-4)
package corral_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    OVER
  } entry_state_t;

  typedef logic signed [2:0] move_t;

  localparam move_t MOVE_ILLEGAL = 3'b100;

endpackage

// File: rtl/debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle pulse on each 0->1 change of the debounced level.
//   clock, reset_n : system clock, async active-low reset
//   raw            : asynchronous button input
//   rise           : one-cycle pulse per debounced press
module debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic          level_prev;
  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      level      <= 1'b0;
      level_prev <= 1'b0;
      count      <= '0;
      rise       <= 1'b0;
    end else begin
      sync_1     <= raw;
      sync_2     <= sync_1;
      level_prev <= level;
      rise       <= level & ~level_prev;
      // The DEBOUNCE_CYCLES-th consecutive disagreeing cycle flips the level.
      if (sync_2 == level) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        level <= ~level;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_entry.sv
// Player-input front end: debounces the enter button, synchronises the
// move switches, rejects the illegal code and hands each accepted move to
// the game core over the enter/move -> ready handshake.
//   clock, reset_n      : system clock, async active-low reset
//   btn_enter, sw_move  : raw asynchronous pins
//   ready, gameover     : status from the game core
//   enter, move         : move strobe and latched move to the core
//   invalid, timeout    : one-cycle event pulses
//   pending             : a move is in flight
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | waiting for a press
// ISSUE     | move latched, waiting for ready to strobe enter
// WAIT_BUSY | enter sent, waiting for the core to drop ready
// WAIT_DONE | core busy, waiting for ready to return
// OVER      | game finished, left only by reset
module move_entry
  import corral_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int ACK_TIMEOUT     = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_enter,
  input  logic [2:0] sw_move,
  input  logic       ready,
  input  logic       gameover,
  output logic       enter,
  output logic [2:0] move,
  output logic       invalid,
  output logic       timeout,
  output logic       pending
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LOAD = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  entry_state_t  state;
  move_t         sw_sync_1;
  move_t         sw_sync_2;
  logic          press;
  logic [TW-1:0] t_count;

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock  (clock),
    .reset_n(reset_n),
    .raw    (btn_enter),
    .rise   (press)
  );

  // The strobe must follow ready and gameover within the same cycle, so it is
  // decoded from the registered state and gated by both live inputs.
  assign enter = (state == ISSUE) && ready && !gameover;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sw_sync_1 <= '0;
      sw_sync_2 <= '0;
      move      <= '0;
      invalid   <= 1'b0;
      timeout   <= 1'b0;
      pending   <= 1'b0;
      t_count   <= '0;
    end else begin
      sw_sync_1 <= move_t'(sw_move);
      sw_sync_2 <= sw_sync_1;
      invalid   <= 1'b0;
      timeout   <= 1'b0;
      if (gameover) begin
        state   <= OVER;
        pending <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (press) begin
              if (sw_sync_2 == MOVE_ILLEGAL) begin
                invalid <= 1'b1;
              end else begin
                move    <= sw_sync_2;
                state   <= ISSUE;
                pending <= 1'b1;
              end
            end
          end
          ISSUE: begin
            if (ready) begin
              state   <= WAIT_BUSY;
              t_count <= T_LOAD;
            end
          end
          WAIT_BUSY: begin
            // timeout is registered one cycle ahead so it is high during the
            // final WAIT_BUSY cycle; that cycle always returns to IDLE.
            if (t_count == '0) begin
              state   <= IDLE;
              pending <= 1'b0;
            end else if (!ready) begin
              state <= WAIT_DONE;
            end else begin
              if (t_count == T_ONE) timeout <= 1'b1;
              t_count <= t_count - 1'b1;
            end
          end
          WAIT_DONE: begin
            if (ready) begin
              state   <= IDLE;
              pending <= 1'b0;
            end
          end
          OVER: begin
            pending <= 1'b0;
          end
          default: begin
            state   <= IDLE;
            pending <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_move_entry.sv
// Directed bench for move_entry with DEBOUNCE_CYCLES=4, ACK_TIMEOUT=16.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_move_entry;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       btn_enter;
  logic [2:0] sw_move;
  logic       ready;
  logic       gameover;
  logic       enter;
  logic [2:0] move;
  logic       invalid;
  logic       timeout;
  logic       pending;

  int n_assert = 0;
  int n_fail   = 0;
  int n_enter;
  int n_to;

  move_entry #(
    .DEBOUNCE_CYCLES(4),
    .ACK_TIMEOUT    (16)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .btn_enter(btn_enter),
    .sw_move  (sw_move),
    .ready    (ready),
    .gameover (gameover),
    .enter    (enter),
    .move     (move),
    .invalid  (invalid),
    .timeout  (timeout),
    .pending  (pending)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0; btn_enter = 1'b0; sw_move = 3'b000; ready = 1'b1; gameover = 1'b0;
    cyc(2);
    chk("rst_enter", enter, 0);
    chk("rst_move", move, 0);
    chk("rst_invalid", invalid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_pending", pending, 0);
    reset_n = 1'b1;
    cyc(2);

    // Clean press: enter exactly 2+4+1+1 cycles after the raw edge.
    sw_move = 3'b010; btn_enter = 1'b1;
    cyc(7);
    chk("clean_enter_early", enter, 0);
    chk("clean_pending_early", pending, 0);
    cyc(1);
    chk("clean_enter", enter, 1);
    chk("clean_move", move, 3'b010);
    chk("clean_pending_issue", pending, 1);
    cyc(1);
    chk("clean_enter_single", enter, 0);
    chk("clean_pending_busy", pending, 1);
    ready = 1'b0;
    cyc(1);
    chk("clean_pending_done", pending, 1);
    ready = 1'b1;
    cyc(1);
    chk("clean_pending_idle", pending, 0);
    btn_enter = 1'b0;
    cyc(10);

    // Bouncing button: one press, one enter (ready stays high -> one timeout).
    sw_move = 3'b001; btn_enter = 1'b1;
    cyc(2); btn_enter = 1'b0;
    cyc(2); btn_enter = 1'b1;
    n_enter = 0; n_to = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (enter === 1'b1) n_enter++;
      if (timeout === 1'b1) n_to++;
    end
    chk("bounce_enter_count", n_enter, 1);
    chk("bounce_timeout_count", n_to, 1);
    chk("bounce_move", move, 3'b001);
    chk("bounce_pending", pending, 0);
    btn_enter = 1'b0;
    cyc(10);

    // Illegal code: invalid one cycle after the press event, move unchanged.
    sw_move = 3'b100; btn_enter = 1'b1;
    cyc(7);
    chk("inv_early", invalid, 0);
    cyc(1);
    chk("inv_pulse", invalid, 1);
    chk("inv_no_enter", enter, 0);
    chk("inv_move_kept", move, 3'b001);
    chk("inv_pending", pending, 0);
    cyc(1);
    chk("inv_single", invalid, 0);
    btn_enter = 1'b0;
    cyc(10);

    // Busy core; second press (event at w20) lands in WAIT_DONE and is dropped.
    sw_move = 3'b101; btn_enter = 1'b1;
    cyc(7);
    btn_enter = 1'b0;
    cyc(1);
    chk("busy_enter", enter, 1);
    chk("busy_move", move, 3'b101);
    for (int i = 9; i <= 30; i++) begin
      cyc(1);
      chk("busy_no_enter", enter, 0);
      chk("busy_no_invalid", invalid, 0);
      chk("busy_pending", pending, (i <= 23) ? 1 : 0);
      if (i == 11) ready = 1'b0;
      if (i == 13) btn_enter = 1'b1;
      if (i == 23) ready = 1'b1;
    end
    chk("busy_move_kept", move, 3'b101);
    btn_enter = 1'b0;
    cyc(10);

    // Timeout: pulse in the 16th WAIT_BUSY cycle, IDLE after it.
    sw_move = 3'b011; btn_enter = 1'b1;
    cyc(8);
    chk("to_enter", enter, 1);
    cyc(15);
    chk("to_not_yet", timeout, 0);
    chk("to_pending_15", pending, 1);
    cyc(1);
    chk("to_pulse", timeout, 1);
    chk("to_pending_16", pending, 1);
    cyc(1);
    chk("to_single", timeout, 0);
    chk("to_idle", pending, 0);
    btn_enter = 1'b0;
    cyc(10);
    sw_move = 3'b111; btn_enter = 1'b1;
    cyc(8);
    chk("to_next_enter", enter, 1);
    chk("to_next_move", move, 3'b111);
    cyc(1);
    ready = 1'b0;
    cyc(1);
    chk("to_next_done", pending, 1);
    ready = 1'b1;
    cyc(1);
    chk("to_next_idle", pending, 0);
    btn_enter = 1'b0;
    cyc(10);

    // Game over while in ISSUE: no enter, presses ignored afterwards.
    ready = 1'b0; sw_move = 3'b010; btn_enter = 1'b1;
    cyc(8);
    chk("go_issue_pending", pending, 1);
    chk("go_issue_no_enter", enter, 0);
    gameover = 1'b1; ready = 1'b1;
    #1;
    chk("go_enter_gated", enter, 0);
    cyc(1);
    chk("go_over_pending", pending, 0);
    chk("go_over_enter", enter, 0);
    btn_enter = 1'b0;
    cyc(10);
    sw_move = 3'b001; btn_enter = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      chk("go_ignored_enter", enter, 0);
      chk("go_ignored_pending", pending, 0);
    end
    chk("go_move_kept", move, 3'b010);
    #2 reset_n = 1'b0;
    #1;
    chk("go_rst_move", move, 0);
    chk("go_rst_pending", pending, 0);
    gameover = 1'b0; btn_enter = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(2);

    // Asynchronous reset in the middle of an enter strobe.
    ready = 1'b1; sw_move = 3'b011; btn_enter = 1'b1;
    cyc(8);
    chk("ar_enter", enter, 1);
    chk("ar_move", move, 3'b011);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_enter_drop", enter, 0);
    chk("ar_move_clr", move, 0);
    chk("ar_pending_clr", pending, 0);
    chk("ar_invalid_clr", invalid, 0);
    chk("ar_timeout_clr", timeout, 0);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
